// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle CPU: opcodes, FSM states, instruction
// field positions and small decode helpers.
package cpu_pkg;

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_MOVI = 4'd1,
        OP_ADD  = 4'd2,
        OP_CMP  = 4'd3,
        OP_JE   = 4'd4,
        OP_JNE  = 4'd5,
        OP_HLT  = 4'd6,
        OP_SUB  = 4'd7,
        OP_JMP  = 4'd8
    } opcode_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_IMM,
        S_EXEC,
        S_HALT
    } state_e;

    typedef enum logic {
        ALU_ADD,
        ALU_SUB
    } alu_op_e;

    localparam int OPC_HI = 7;
    localparam int OPC_LO = 4;
    localparam int RD_HI  = 3;
    localparam int RD_LO  = 2;
    localparam int RS_HI  = 1;
    localparam int RS_LO  = 0;

    // Opcodes followed by an immediate byte
    function automatic logic hasImm(input logic [3:0] opc);
        case (opc)
            OP_MOVI, OP_CMP, OP_JE, OP_JNE, OP_JMP: return 1'b1;
            default:                                return 1'b0;
        endcase
    endfunction

    function automatic logic isLegalOpc(input logic [3:0] opc);
        return opc <= OP_JMP;
    endfunction

endpackage

// File: rtl/cpu_alu.sv
// Add/subtract unit with zero and carry/borrow flags; the extra result bit
// carries out on ADD and holds the borrow on SUB.
module cpu_alu
    import cpu_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic [DW-1:0] i_a,
    input  logic [DW-1:0] i_b,
    input  alu_op_e       i_op,
    output logic [DW-1:0] o_result,
    output logic          o_carry,
    output logic          o_zero
);

    logic [DW:0] w_ext;

    assign w_ext    = (i_op == ALU_ADD) ? ({1'b0, i_a} + {1'b0, i_b})
                                        : ({1'b0, i_a} - {1'b0, i_b});
    assign o_result = w_ext[DW-1:0];
    assign o_carry  = w_ext[DW];
    assign o_zero   = (w_ext[DW-1:0] == '0);

endmodule

// File: rtl/multicycle_cpu.sv
// Small multicycle CPU: byte-wide instruction memory loaded externally,
// FETCH/IMM/EXEC sequencing, NREGS general registers and Z/C flags.
module multicycle_cpu
    import cpu_pkg::*;
#(
    parameter int DW         = 8,
    parameter int NREGS      = 4,
    parameter int IMEM_DEPTH = 16,
    localparam int PW        = $clog2(IMEM_DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          load_en,
    input  logic [PW-1:0] load_addr,
    input  logic [7:0]    load_data,
    input  logic [1:0]    dbg_sel,
    output logic [DW-1:0] dbg_data,
    output logic [PW-1:0] pc_out,
    output logic          halted,
    output logic          err
);

    state_e        r_state;
    state_e        w_nextState;
    logic [7:0]    r_imem [IMEM_DEPTH];
    logic [7:0]    r_ir;
    logic [7:0]    r_imm;
    logic [PW-1:0] r_pc;
    logic [DW-1:0] r_regs [NREGS];
    logic          r_zFlag;
    logic          r_cFlag;
    logic          r_err;

    logic [3:0]    w_opcode;
    logic [1:0]    w_rd;
    logic [1:0]    w_rs;
    logic [7:0]    w_fetchByte;
    logic          w_idleLike;
    logic          w_loadAccept;
    logic          w_illegal;
    logic          w_jumpTaken;
    logic [DW-1:0] w_immExt;
    logic [DW-1:0] w_rdVal;
    logic [DW-1:0] w_rsVal;
    logic [DW-1:0] w_aluB;
    alu_op_e       w_aluOp;
    logic [DW-1:0] w_aluResult;
    logic          w_aluCarry;
    logic          w_aluZero;

    assign w_opcode     = r_ir[OPC_HI:OPC_LO];
    assign w_rd         = r_ir[RD_HI:RD_LO];
    assign w_rs         = r_ir[RS_HI:RS_LO];
    assign w_fetchByte  = r_imem[r_pc];
    assign w_idleLike   = (r_state == S_IDLE) || (r_state == S_HALT);
    assign w_loadAccept = load_en && w_idleLike && !start;
    assign w_illegal    = !isLegalOpc(w_opcode) || (int'(w_rd) >= NREGS)
                          || (int'(w_rs) >= NREGS);
    assign w_immExt     = DW'(r_imm);
    assign w_rdVal      = r_regs[w_rd];
    assign w_rsVal      = r_regs[w_rs];
    assign w_aluB       = (w_opcode == OP_CMP) ? w_immExt : w_rsVal;
    assign w_aluOp      = (w_opcode == OP_ADD) ? ALU_ADD : ALU_SUB;
    assign w_jumpTaken  = (w_opcode == OP_JMP)
                          || ((w_opcode == OP_JE)  &&  r_zFlag)
                          || ((w_opcode == OP_JNE) && !r_zFlag);

    assign pc_out = r_pc;
    assign halted = (r_state == S_HALT);
    assign err    = r_err;

    cpu_alu #(.DW(DW)) u_alu (
        .i_a      (w_rdVal),
        .i_b      (w_aluB),
        .i_op     (w_aluOp),
        .o_result (w_aluResult),
        .o_carry  (w_aluCarry),
        .o_zero   (w_aluZero)
    );

    always_comb begin
        dbg_data = '0;
        if (int'(dbg_sel) < NREGS) begin
            dbg_data = r_regs[dbg_sel];
        end
    end

    // Program memory is deliberately left out of reset so a loaded program survives it
    always_ff @(posedge clk) begin
        if (w_loadAccept) begin
            r_imem[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE, S_HALT: if (start) w_nextState = S_FETCH;
            S_FETCH:        w_nextState = hasImm(w_fetchByte[OPC_HI:OPC_LO]) ? S_IMM : S_EXEC;
            S_IMM:          w_nextState = S_EXEC;
            S_EXEC:         w_nextState = (w_illegal || (w_opcode == OP_HLT)) ? S_HALT : S_FETCH;
            default:        w_nextState = S_IDLE;
        endcase
    end

    // Datapath: pc wraps naturally through its PW-bit width
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc    <= '0;
            r_ir    <= '0;
            r_imm   <= '0;
            r_zFlag <= 1'b0;
            r_cFlag <= 1'b0;
            r_err   <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        r_pc  <= '0;
                        r_err <= 1'b0;
                    end
                end
                S_FETCH: begin
                    r_ir <= w_fetchByte;
                    r_pc <= r_pc + 1'b1;
                end
                S_IMM: begin
                    r_imm <= w_fetchByte;
                    r_pc  <= r_pc + 1'b1;
                end
                S_EXEC: begin
                    if (w_illegal) begin
                        r_err <= 1'b1;
                    end else begin
                        case (w_opcode)
                            OP_MOVI: r_regs[w_rd] <= w_immExt;
                            OP_ADD, OP_SUB: begin
                                r_regs[w_rd] <= w_aluResult;
                                r_zFlag      <= w_aluZero;
                                r_cFlag      <= w_aluCarry;
                            end
                            OP_CMP: begin
                                r_zFlag <= w_aluZero;
                                r_cFlag <= w_aluCarry;
                            end
                            OP_JE, OP_JNE, OP_JMP: begin
                                if (w_jumpTaken) r_pc <= r_imm[PW-1:0];
                            end
                            default: ;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_cpu.sv
// Scoreboard bench for multicycle_cpu: stimulus queues the expected halt
// state of each program run; a monitor checks it when halted rises.
module tb_multicycle_cpu;
    import cpu_pkg::*;

    localparam int DW = 8;
    localparam int NREGS = 4;
    localparam int IMEM_DEPTH = 16;
    localparam int PW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          load_en = 1'b0;
    logic [PW-1:0] load_addr = '0;
    logic [7:0]    load_data = '0;
    logic [1:0]    dbg_sel = '0;
    logic [DW-1:0] dbg_data;
    logic [PW-1:0] pc_out;
    logic          halted;
    logic          err;

    multicycle_cpu #(.DW(DW), .NREGS(NREGS), .IMEM_DEPTH(IMEM_DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data),
        .dbg_sel   (dbg_sel),
        .dbg_data  (dbg_data),
        .pc_out    (pc_out),
        .halted    (halted),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string           name;
        int              cycles;
        logic            err;
        logic [3:0][7:0] regs;
        logic            z;
        logic            c;
        logic [3:0]      pc;
    } expect_t;

    expect_t    sb[$];
    expect_t    curExp;
    int         cyc = 0;
    int         startCyc = 0;
    int         nChecks = 0;
    int         nPass = 0;
    logic       prevHalted = 1'b0;
    logic [7:0] prog[$];

    always @(posedge clk) cyc++;

    function automatic expect_t mkExp(input string name, input int cycles, input logic e,
                                      input logic [7:0] r0, input logic [7:0] r1,
                                      input logic [7:0] r2, input logic [7:0] r3,
                                      input logic z, input logic c, input logic [3:0] pc);
        expect_t x;
        x.name = name;
        x.cycles = cycles;
        x.err = e;
        x.regs[0] = r0;
        x.regs[1] = r1;
        x.regs[2] = r2;
        x.regs[3] = r3;
        x.z = z;
        x.c = c;
        x.pc = pc;
        return x;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        nChecks++;
        if (actual === required) nPass++;
        else $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, required);
    endtask

    task automatic checkRegs(input string name, input logic [3:0][7:0] required);
        for (int i = 0; i < NREGS; i++) begin
            dbg_sel = 2'(i);
            #1;
            checkOutput($sformatf("%s r%0d", name, i), dbg_data, required[i]);
        end
    endtask

    // Monitor: one queued expectation is consumed per rising edge of halted
    always @(negedge clk) begin
        if (halted && !prevHalted) begin
            if (sb.size() == 0) begin
                nChecks++;
                $display("[TB] FAIL unexpected_halt: got halted=1, required no halt (pc=%0d)", pc_out);
            end else begin
                curExp = sb[0];
                checkOutput({curExp.name, " cycles"}, cyc - startCyc, curExp.cycles);
                checkOutput({curExp.name, " err"}, err, curExp.err);
                checkOutput({curExp.name, " pc"}, pc_out, curExp.pc);
                checkOutput({curExp.name, " Z"}, dut.r_zFlag, curExp.z);
                checkOutput({curExp.name, " C"}, dut.r_cFlag, curExp.c);
                checkRegs(curExp.name, curExp.regs);
                void'(sb.pop_front());
            end
        end
        prevHalted = halted;
    end

    task automatic loadByte(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        load_en = 1'b1;
        load_addr = a;
        load_data = d;
        @(negedge clk);
        load_en = 1'b0;
    endtask

    task automatic loadProgram();
        for (int i = 0; i < prog.size(); i++) loadByte(4'(i), prog[i]);
    endtask

    task automatic applyStimulus(input expect_t e, input bit pushExp, input bit withLoad,
                                 input logic [3:0] la, input logic [7:0] ld);
        @(negedge clk);
        if (pushExp) sb.push_back(e);
        startCyc = cyc + 1;
        start = 1'b1;
        if (withLoad) begin
            load_en = 1'b1;
            load_addr = la;
            load_data = ld;
        end
        @(negedge clk);
        start = 1'b0;
        load_en = 1'b0;
    endtask

    task automatic waitDone(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            nChecks++;
            $display("[TB] FAIL %s timeout: got no halt in 300 cycles, required halt", name);
            sb.delete();
        end
    endtask

    initial begin
        expect_t e;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("reset pc", pc_out, 0);
        checkOutput("reset halted", halted, 0);
        checkOutput("reset err", err, 0);
        checkOutput("reset state", dut.r_state, S_IDLE);
        checkRegs("reset", 32'h0);

        // MOVI/MOVI/ADD/CMP/JE taken over two NOPs to HLT at 11
        prog = '{8'h14, 8'h03, 8'h18, 8'h03, 8'h26, 8'h34, 8'h06, 8'h40, 8'h0B, 8'h00, 8'h00, 8'h60};
        loadProgram();
        e = mkExp("je_prog", 16, 1'b0, 8'd0, 8'd6, 8'd3, 8'd0, 1'b1, 1'b0, 4'd12);
        applyStimulus(e, 1'b1, 1'b0, 4'd0, 8'd0);
        waitDone("je_prog");

        // 200 + 100 wraps to 44 with carry
        prog = '{8'h10, 8'd200, 8'h14, 8'd100, 8'h21, 8'h60};
        loadProgram();
        e = mkExp("add_carry", 10, 1'b0, 8'd44, 8'd100, 8'd3, 8'd0, 1'b0, 1'b1, 4'd6);
        applyStimulus(e, 1'b1, 1'b0, 4'd0, 8'd0);
        waitDone("add_carry");

        loadByte(4'd0, 8'hF0);
        e = mkExp("illegal", 2, 1'b1, 8'd44, 8'd100, 8'd3, 8'd0, 1'b0, 1'b1, 4'd1);
        applyStimulus(e, 1'b1, 1'b0, 4'd0, 8'd0);
        waitDone("illegal");

        prog = '{8'h10, 8'h00, 8'h14, 8'h01, 8'h60};
        loadProgram();
        e = mkExp("setup", 8, 1'b0, 8'd0, 8'd1, 8'd3, 8'd0, 1'b0, 1'b1, 4'd5);
        applyStimulus(e, 1'b1, 1'b0, 4'd0, 8'd0);
        waitDone("setup");

        // Loop through a NOP at 15 that must wrap to 0 and run ADD a second time
        prog = '{8'h21, 8'h30, 8'h02, 8'h50, 8'h0F, 8'h60};
        loadProgram();
        loadByte(4'd15, 8'h00);
        e = mkExp("pc_wrap", 20, 1'b0, 8'd2, 8'd1, 8'd3, 8'd0, 1'b1, 1'b0, 4'd6);
        applyStimulus(e, 1'b1, 1'b0, 4'd0, 8'd0);
        waitDone("pc_wrap");

        // JMP 15; MOVI r3 at 15 takes its immediate (0x83) from address 0
        prog = '{8'h83, 8'h0F, 8'h60};
        loadProgram();
        loadByte(4'd15, 8'h1C);
        e = mkExp("imm_wrap", 10, 1'b0, 8'd2, 8'd1, 8'd3, 8'h83, 1'b1, 1'b0, 4'd3);
        applyStimulus(e, 1'b1, 1'b0, 4'd0, 8'd0);
        waitDone("imm_wrap");

        // Reset while the ADD at address 4 is in EXEC
        prog = '{8'h10, 8'd200, 8'h14, 8'd100, 8'h21, 8'h60};
        loadProgram();
        applyStimulus(e, 1'b0, 1'b0, 4'd0, 8'd0);
        repeat (7) @(negedge clk);
        checkOutput("midexec state", dut.r_state, S_EXEC);
        checkOutput("midexec ir", dut.r_ir, 8'h21);
        reset = 1'b1;
        #1;
        checkOutput("rst state", dut.r_state, S_IDLE);
        checkOutput("rst pc", pc_out, 0);
        checkOutput("rst halted", halted, 0);
        checkOutput("rst Z", dut.r_zFlag, 0);
        checkOutput("rst C", dut.r_cFlag, 0);
        checkRegs("rst", 32'h0);
        checkOutput("rst imem4", dut.r_imem[4], 8'h21);
        @(negedge clk);
        reset = 1'b0;
        e = mkExp("rerun", 10, 1'b0, 8'd44, 8'd100, 8'd0, 8'd0, 1'b0, 1'b1, 4'd6);
        applyStimulus(e, 1'b1, 1'b0, 4'd0, 8'd0);
        waitDone("rerun");

        // A load attempted while running must not replace the HLT at 5
        e.name = "load_running";
        applyStimulus(e, 1'b1, 1'b0, 4'd0, 8'd0);
        loadByte(4'd5, 8'h00);
        waitDone("load_running");

        e.name = "start_and_load";
        applyStimulus(e, 1'b1, 1'b1, 4'd5, 8'h00);
        waitDone("start_and_load");
        checkOutput("imem5 kept", dut.r_imem[5], 8'h60);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
